// File: rtl/ham_seq_ctrl.sv
// ham_seq_ctrl: multi-cycle Hamming-weight sequencer.
// Computes the weight (count of ones, or of zeros when in_op=1) of a WIDTH-bit
// operand by pushing it through a single SLICE-bit popcount, one slice per
// cycle, into an accumulator. An optional early exit stops as soon as every
// unprocessed bit is zero.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand request valid
//   in_ready   controller can accept an operand (IDLE only)
//   in_data    operand, WIDTH bits
//   in_op      0 = count ones, 1 = count zeros (sampled on the accept edge)
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   out_data   weight, zero-extended to WIDTH bits; holds until next result
//   busy       high whenever the sequencer is not IDLE
module ham_seq_ctrl #(
  parameter int WIDTH      = 32,
  parameter int SLICE      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int ACC_W  = $clog2(WIDTH) + 1;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   shreg, shreg_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0]   result, result_next;
  logic [ACC_W-1:0]   slice_sum;
  logic [ACC_W-1:0]   acc_sum;
  logic               last_slice;

  // Popcount of one slice; the accumulator width always covers SLICE.
  function automatic logic [ACC_W-1:0] slice_pop(input logic [SLICE-1:0] s);
    logic [ACC_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < SLICE; i++) begin
      sum = sum + {{(ACC_W-1){1'b0}}, s[i]};
    end
    return sum;
  endfunction

  assign slice_sum = slice_pop(shreg[SLICE-1:0]);
  assign acc_sum   = acc + slice_sum;

  // The slice being consumed now is the last one either by count, or because
  // nothing but zeros remains above it (early exit).
  assign last_slice = (cnt == CNT_W'(NSLICE - 1)) ||
                      ((EARLY_EXIT != 0) && ((shreg >> SLICE) == '0));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state  <= state_next;
      shreg  <= shreg_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
      result <= result_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next  = state;
    shreg_next  = shreg;
    acc_next    = acc;
    cnt_next    = cnt;
    result_next = result;
    case (state)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is the accept.
        if (in_valid) begin
          shreg_next = in_op ? ~in_data : in_data;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        acc_next   = acc_sum;
        shreg_next = shreg >> SLICE;
        cnt_next   = cnt + CNT_W'(1);
        if (last_slice) begin
          // Final sum includes the slice consumed on this edge.
          result_next = {{(WIDTH-ACC_W){1'b0}}, acc_sum};
          state_next  = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = result;

endmodule

// File: tb/tb_ham_seq_ctrl.sv
module tb_ham_seq_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  iv;
  logic [1:0]  ordy;
  logic [31:0] in_data;
  logic        in_op;
  logic [1:0]  irdy;
  logic [1:0]  ov;
  logic [1:0]  bsy;
  logic [31:0] od [2];

  int passed = 0;
  int total  = 0;

  // Behavioural model per DUT (index 0: early exit on, index 1: off).
  // ph: 0 waiting for operand, 1 computing, 2 result offered.
  int          ph [2];
  int          rem [2];
  int          res [2];
  logic [31:0] mout [2];
  int          acc_cnt [2];
  int          nx [2];
  int          acc_e [2][8];
  int          xfer_e [2][8];
  int          xfer_v [2][8];
  int          ecount = 0;

  ham_seq_ctrl #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(in_data), .in_op(in_op),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bsy[0])
  );

  ham_seq_ctrl #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(in_data), .in_op(in_op),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end else begin
      passed++;
    end
  endtask

  // Slices the sequencer consumes for operand v (after the ones/zeros flip).
  function automatic int nslices(input logic [31:0] v, input bit ee);
    int k;
    if (!ee) return 4;
    k = 1;
    while (k < 4 && (v >> (8 * k)) != 32'd0) k++;
    return k;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; rem[i] = 0; res[i] = 0; mout[i] = 32'd0;
    end
  endtask

  task automatic model_edge(input int i);
    logic [31:0] v;
    if (ph[i] == 0) begin
      if (iv[i]) begin
        v = in_op ? ~in_data : in_data;
        res[i] = $countones(v);
        rem[i] = nslices(v, (i == 0));
        ph[i] = 1;
        if (acc_cnt[i] < 8) acc_e[i][acc_cnt[i]] = ecount;
        acc_cnt[i]++;
      end
    end else if (ph[i] == 1) begin
      rem[i]--;
      if (rem[i] == 0) begin
        ph[i] = 2;
        mout[i] = 32'(res[i]);
      end
    end else if (ordy[i]) begin
      if (nx[i] < 8) begin
        xfer_e[i][nx[i]] = ecount;
        xfer_v[i][nx[i]] = res[i];
      end
      nx[i]++;
      ph[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d in_ready", i),  32'(irdy[i]), 32'(ph[i] == 0));
      check($sformatf("dut%0d out_valid", i), 32'(ov[i]),   32'(ph[i] == 2));
      check($sformatf("dut%0d busy", i),      32'(bsy[i]),  32'(ph[i] != 0));
      check($sformatf("dut%0d out_data", i),  od[i],        mout[i]);
    end
  endtask

  // One clock: inputs were set after the previous falling edge.
  task automatic step();
    @(posedge clk);
    ecount++;
    if (!rst) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic op_both(input logic [31:0] data, input logic op, input int w,
                         input int l0, input int l1);
    int k;
    int lat [2];
    logic [31:0] got [2];
    in_data = data; in_op = op; iv = 2'b11; ordy = 2'b11;
    step();
    check("in_ready after accept", 32'(irdy), 32'd0);
    iv = 2'b00; in_data = $urandom; in_op = ~op;
    lat[0] = 0; lat[1] = 0; got[0] = 32'd0; got[1] = 32'd0; k = 0;
    while (k < 20 && !(lat[0] != 0 && lat[1] != 0 && irdy == 2'b11)) begin
      step();
      k++;
      for (int i = 0; i < 2; i++) begin
        if (ov[i] && lat[i] == 0) begin
          lat[i] = k; got[i] = od[i];
        end
      end
    end
    check($sformatf("latency ee %08h", data),   32'(lat[0]), 32'(l0));
    check($sformatf("latency full %08h", data), 32'(lat[1]), 32'(l1));
    check($sformatf("weight ee %08h", data),    got[0], 32'(w));
    check($sformatf("weight full %08h", data),  got[1], 32'(w));
    check($sformatf("idle edge %08h", data), 32'(k), 32'(((l0 > l1) ? l0 : l1) + 1));
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async rst dut%0d in_ready", i),  32'(irdy[i]), 32'd1);
      check($sformatf("async rst dut%0d out_valid", i), 32'(ov[i]),   32'd0);
      check($sformatf("async rst dut%0d busy", i),      32'(bsy[i]),  32'd0);
      check($sformatf("async rst dut%0d out_data", i),  od[i],        32'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    logic [31:0] a_op;
    logic [31:0] b_op;
    int          k;
    int          sel;
    rst = 1'b1; iv = 2'b00; ordy = 2'b00; in_data = 32'd0; in_op = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      acc_cnt[i] = 0; nx[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    check("reset in_ready", 32'(irdy), 32'd3);

    // 1..3: directed weights and latencies (ee, full)
    op_both(32'hFFFFFFFF, 1'b0, 32, 4, 4);
    op_both(32'h000000FF, 1'b0, 8, 1, 4);
    op_both(32'hF0F00001, 1'b1, 23, 4, 4);
    op_both(32'hFFFFFFFF, 1'b1, 0, 1, 4);

    // 4: backpressure with stray in_valid pulses
    in_data = 32'h12345678; in_op = 1'b0; iv = 2'b11; ordy = 2'b00;
    step();
    for (int c = 0; c < 14; c++) begin
      iv = 2'($urandom_range(0, 3)); in_data = $urandom; in_op = 1'($urandom);
      step();
    end
    check("backpressure out_valid", 32'(ov), 32'd3);
    check("backpressure ee data", od[0], 32'd13);
    check("backpressure full data", od[1], 32'd13);
    iv = 2'b00; ordy = 2'b11;
    step();
    check("release out_valid", 32'(ov), 32'd0);
    check("release in_ready", 32'(irdy), 32'd3);
    check("release held data", od[1], 32'd13);

    // 5: asynchronous abort mid-run
    in_data = 32'hAAAAAAAA; in_op = 1'b0; iv = 2'b11; ordy = 2'b11;
    step();
    iv = 2'b00;
    step();
    async_reset();
    op_both(32'h00000003, 1'b0, 2, 1, 4);

    // 6: back-to-back with out_ready tied high
    a_op = 32'h80000000; b_op = 32'h00010001;
    for (int i = 0; i < 2; i++) begin
      acc_cnt[i] = 0; nx[i] = 0;
    end
    ordy = 2'b11; in_op = 1'b0; k = 0;
    while (k < 40 && !(nx[0] >= 2 && nx[1] >= 2)) begin
      in_data = (acc_cnt[0] == 0) ? a_op : b_op;
      iv[0] = (acc_cnt[0] < 2);
      iv[1] = (acc_cnt[1] < 2);
      step();
      k++;
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("b2b dut%0d results", i), 32'(nx[i]), 32'd2);
      check($sformatf("b2b dut%0d first", i),   32'(xfer_v[i][0]), 32'd1);
      check($sformatf("b2b dut%0d second", i),  32'(xfer_v[i][1]), 32'd2);
      check($sformatf("b2b dut%0d gap", i),     32'(acc_e[i][1] - xfer_e[i][0]), 32'd1);
    end
    iv = 2'b00;
    repeat (6) step();

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      iv = 2'($urandom); ordy = 2'($urandom); in_op = 1'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
        0: in_data = $urandom;
        1: in_data = $urandom & 32'h000000FF;
        2: in_data = 32'hFFFFFFFF;
        default: in_data = $urandom >> $urandom_range(0, 31);
      endcase
      step();
    end
    iv = 2'b00; ordy = 2'b11;
    repeat (8) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
